// File: rtl/shift_reg_pkg.sv
// Shared definitions for the multimode shift register and its timing helpers.
// Mode field encoding and type.
package shift_reg_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD   = 3'd0;
  localparam mode_t MODE_SHL    = 3'd1;
  localparam mode_t MODE_SHR    = 3'd2;
  localparam mode_t MODE_ROL    = 3'd3;
  localparam mode_t MODE_ROR    = 3'd4;
  localparam mode_t MODE_BOUNCE = 3'd5;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-clock strobe every DIV enabled cycles.
// Usable by any timed block in place of a derived clock.
module tick_gen #(
  parameter int DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_reg_multimode.sv
// W-bit register with hold/shift/rotate/bounce modes and parallel load,
// advanced by an internal prescaler tick.
module shift_reg_multimode
  import shift_reg_pkg::*;
#(
  parameter int           W    = 8,
  parameter int           DIV  = 1000000,
  parameter logic [W-1:0] INIT = W'(1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  mode_t        mode,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         sin,
  output logic [W-1:0] data,
  output logic         tick,
  output logic         dir
);

  logic [W-1:0] data_q, data_d;
  logic         dir_q, dir_d;

  tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    if (load) begin
      data_d = din;
    end else if (tick) begin
      case (mode)
        MODE_SHL: data_d = {data_q[W-2:0], sin};
        MODE_SHR: data_d = {sin, data_q[W-1:1]};
        MODE_ROL: data_d = {data_q[W-2:0], data_q[W-1]};
        MODE_ROR: data_d = {data_q[0], data_q[W-1:1]};
        MODE_BOUNCE: begin
          // Reverse at the edge, moving away from it on the same tick.
          if (!dir_q && data_q[W-1]) begin
            dir_d  = 1'b1;
            data_d = data_q >> 1;
          end else if (dir_q && data_q[0]) begin
            dir_d  = 1'b0;
            data_d = data_q << 1;
          end else if (dir_q) begin
            data_d = data_q >> 1;
          end else begin
            data_d = data_q << 1;
          end
        end
        default: data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= INIT;
      dir_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
    end
  end

  assign data = data_q;
  assign dir  = dir_q;

endmodule

// File: tb/tb_shift_reg_multimode.sv
// Directed bench for shift_reg_multimode at W=8, DIV=4, INIT=01.
// Inputs driven and outputs sampled on the falling edge.
module tb_shift_reg_multimode;
  import shift_reg_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  mode_t      mode = MODE_HOLD;
  logic       load = 1'b0;
  logic [7:0] din = 8'h00;
  logic       sin = 1'b0;
  logic [7:0] data;
  logic       tick;
  logic       dir;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  shift_reg_multimode #(
    .W    (8),
    .DIV  (4),
    .INIT (8'h01)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .load (load),
    .din  (din),
    .sin  (sin),
    .data (data),
    .tick (tick),
    .dir  (dir)
  );

  // Wait (bounded) for tick, then pass the edge it drives.
  task automatic tick_step();
    int n = 0;
    while (tick !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (tick !== 1'b1) begin
      failed++;
      $display("FAIL tick_wait: tick=%b expected 1 within 16 clks", tick);
    end
    @(negedge clk);
  endtask

  task automatic load_val(input logic [7:0] v);
    en   = 1'b0;
    load = 1'b1;
    din  = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    load = 1'b1;
    din = 8'hFF;
    repeat (2) @(negedge clk);
    load = 1'b0;
    en = 1'b0;
    tests++;
    if (data !== 8'h01) begin
      failed++;
      $display("FAIL reset_data: got %h expected 01", data);
    end
    tests++;
    if (dir !== 1'b0) begin
      failed++;
      $display("FAIL reset_dir: got %b expected 0", dir);
    end
    tests++;
    if (tick !== 1'b0) begin
      failed++;
      $display("FAIL reset_tick: got %b expected 0", tick);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rol();
    logic [7:0] exp_v;
    mode = MODE_ROL;
    en = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (tick !== 1'b0) begin
      failed++;
      $display("FAIL rol_early_tick: got %b expected 0", tick);
    end
    @(negedge clk);
    tests++;
    if (tick !== 1'b1 || data !== 8'h01) begin
      failed++;
      $display("FAIL rol_first_tick: tick=%b data=%h expected 1/01", tick, data);
    end
    @(negedge clk);
    tests++;
    if (data !== 8'h02) begin
      failed++;
      $display("FAIL rol_first_data: got %h expected 02", data);
    end
    exp_v = 8'h02;
    for (int i = 0; i < 7; i++) begin
      tick_step();
      exp_v = {exp_v[6:0], exp_v[7]};
    end
    tests++;
    if (data !== 8'h01 || exp_v !== 8'h01) begin
      failed++;
      $display("FAIL rol_wrap: got %h expected 01", data);
    end
  endtask

  task automatic test_ror();
    int bad = 0;
    mode = MODE_ROR;
    tick_step();
    tests++;
    if (data !== 8'h80) begin
      failed++;
      $display("FAIL ror_1: got %h expected 80", data);
    end
    tick_step();
    tests++;
    if (data !== 8'h40) begin
      failed++;
      $display("FAIL ror_2: got %h expected 40", data);
    end
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tick !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0 || data !== 8'h40) begin
      failed++;
      $display("FAIL ror_freeze: data=%h ticks=%0d expected 40/0", data, bad);
    end
    en = 1'b1;
    @(negedge clk);
    tests++;
    if (tick !== 1'b0) begin
      failed++;
      $display("FAIL ror_resume_early: tick=%b expected 0", tick);
    end
    @(negedge clk);
    tests++;
    if (tick !== 1'b1) begin
      failed++;
      $display("FAIL ror_resume_tick: tick=%b expected 1", tick);
    end
    @(negedge clk);
    tests++;
    if (data !== 8'h20) begin
      failed++;
      $display("FAIL ror_resume_data: got %h expected 20", data);
    end
  endtask

  task automatic test_shl();
    logic [3:0] bits = 4'b1101;
    logic [7:0] exp_tab [4] = '{8'h01, 8'h02, 8'h05, 8'h0B};
    load_val(8'h00);
    tests++;
    if (data !== 8'h00) begin
      failed++;
      $display("FAIL shl_load: got %h expected 00", data);
    end
    mode = MODE_SHL;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sin = bits[i];
      tick_step();
      tests++;
      if (data !== exp_tab[i]) begin
        failed++;
        $display("FAIL shl_%0d: got %h expected %h", i, data, exp_tab[i]);
      end
    end
    sin = 1'b0;
  endtask

  task automatic test_bounce();
    load_val(8'h01);
    mode = MODE_BOUNCE;
    en = 1'b1;
    for (int i = 0; i < 7; i++) tick_step();
    tests++;
    if (data !== 8'h80 || dir !== 1'b0) begin
      failed++;
      $display("FAIL bounce_top: data=%h dir=%b expected 80/0", data, dir);
    end
    tick_step();
    tests++;
    if (data !== 8'h40 || dir !== 1'b1) begin
      failed++;
      $display("FAIL bounce_rev_r: data=%h dir=%b expected 40/1", data, dir);
    end
    for (int i = 0; i < 6; i++) tick_step();
    tests++;
    if (data !== 8'h01 || dir !== 1'b1) begin
      failed++;
      $display("FAIL bounce_bot: data=%h dir=%b expected 01/1", data, dir);
    end
    tick_step();
    tests++;
    if (data !== 8'h02 || dir !== 1'b0) begin
      failed++;
      $display("FAIL bounce_rev_l: data=%h dir=%b expected 02/0", data, dir);
    end
    load_val(8'h00);
    en = 1'b1;
    tick_step();
    tick_step();
    tests++;
    if (data !== 8'h00) begin
      failed++;
      $display("FAIL bounce_zero: got %h expected 00", data);
    end
  endtask

  task automatic test_load();
    int n = 0;
    load_val(8'h01);
    mode = MODE_ROL;
    en = 1'b1;
    while (tick !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    load = 1'b1;
    din = 8'hA5;
    @(negedge clk);
    load = 1'b0;
    tests++;
    if (data !== 8'hA5) begin
      failed++;
      $display("FAIL load_on_tick: got %h expected a5", data);
    end
    tick_step();
    tests++;
    if (data !== 8'h4B) begin
      failed++;
      $display("FAIL load_then_rol: got %h expected 4b", data);
    end
    load_val(8'h3C);
    tests++;
    if (data !== 8'h3C || tick !== 1'b0) begin
      failed++;
      $display("FAIL load_en0: data=%h tick=%b expected 3c/0", data, tick);
    end
  endtask

  task automatic test_rst_mid();
    load_val(8'h80);
    mode = MODE_BOUNCE;
    en = 1'b1;
    for (int i = 0; i < 3; i++) tick_step();
    tests++;
    if (data !== 8'h10 || dir !== 1'b1) begin
      failed++;
      $display("FAIL rst_pre: data=%h dir=%b expected 10/1", data, dir);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (data !== 8'h01 || dir !== 1'b0 || tick !== 1'b0) begin
      failed++;
      $display("FAIL rst_mid: data=%h dir=%b tick=%b expected 01/0/0",
               data, dir, tick);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (tick !== 1'b0) begin
      failed++;
      $display("FAIL rst_early_tick: tick=%b expected 0", tick);
    end
    @(negedge clk);
    tests++;
    if (tick !== 1'b1 || data !== 8'h01) begin
      failed++;
      $display("FAIL rst_tick: tick=%b data=%h expected 1/01", tick, data);
    end
    @(negedge clk);
    tests++;
    if (data !== 8'h02 || dir !== 1'b0) begin
      failed++;
      $display("FAIL rst_after: data=%h dir=%b expected 02/0", data, dir);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_rol();
    test_ror();
    test_shl();
    test_bounce();
    test_load();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/shift_reg_multimode.md
Name: shift_reg_multimode

Overview:
- Parametrised successor of the team's fixed 8-bit rotating LED register.
- W-bit register that advances once per internal prescaler tick and supports:
  - hold
  - serial shift left/right
  - rotate left/right
  - ping-pong "bounce"
  - synchronous parallel load
- Sits between the board clock and LED/output pins, or feeds downstream pattern logic.
- Tick generation is internal, so no separate derived clock is needed; everything runs on one clock domain.

Parameters:
- W, 8: register width in bits, ≥2.
- DIV, 1000000: clock cycles per shift tick, ≥1.
- INIT, 1: reset value of data, W bits wide.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  prescaler run enable; 0 freezes the tick counter.
- mode  in  3  operation select (encoding below).
- load  in  1  synchronous parallel load strobe.
- din  in  W  parallel load value.
- sin  in  1  serial input bit for shift modes.
- data  out  W  register contents, registered.
- tick  out  1  one-clk strobe; high in the cycle data advances.
- dir  out  1  bounce direction: 0 = left (toward MSB), 1 = right.

Behaviour:
- Reset (rst=1 at a clk edge):
  - data=INIT, dir=0, prescaler count=0, tick=0.
  - Reset overrides load and en.
- Prescaler:
  - Counter width is clog2(DIV), minimum 1.
  - With en=1, the counter increments each clk.
  - When count==DIV-1: tick=1 for that cycle, and the counter wraps to 0 at the next edge.
  - With en=0: counter holds and tick=0.
  - DIV=1 gives tick=1 every cycle while en=1.
  - tick is combinational from the counter, so it is valid in the same cycle the shift edge occurs.
- Update priority at each clk edge:
  - rst > load > tick-driven mode action > hold.
- Load:
  - load=1 gives data<=din on that edge, regardless of tick or en.
  - Load does not touch the prescaler count or dir.
- Mode actions, applied only on an edge where tick=1 and load=0:
  - 0 HOLD: data unchanged.
  - 1 SHL: data <= {data[W-2:0], sin}.
  - 2 SHR: data <= {sin, data[W-1:1]}.
  - 3 ROL: data <= {data[W-2:0], data[W-1]}.
  - 4 ROR: data <= {data[0], data[W-1:1]}.
  - 5 BOUNCE: logical shift with 0 fill in direction dir, with reversal at the ends:
    - If dir=0 and data[W-1]=1: dir<=1 and data shifts right this tick.
    - If dir=1 and data[0]=1: dir<=0 and data shifts left this tick.
    - Otherwise: shift in the current dir, dir unchanged.
    - data==0 stays 0.
  - 6, 7: reserved, treated as HOLD.
- dir changes only in mode 5 or on reset; other modes leave it unchanged.
- Mode may change on any cycle. The value sampled on the tick edge governs that update; no pipelining of mode.
- Latency:
  - One clk from a tick edge to the new data.
  - First tick after reset occurs DIV clks after en is first sampled high.
- Reset mid-operation: all state returns to reset values on the next edge; no partial shift is retained.

Decomposition:
- Shared package `shift_reg_pkg`:
  - Mode encoding constants MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_BOUNCE.
  - Typedef for the 3-bit mode field.
- One sub-module, `tick_gen`:
  - Parameters: DIV.
  - Ports: clk, rst, en, tick.
  - Contains the prescaler counter.
  - Reusable by other timed blocks in place of derived clocks.

Test Plan (W=8, DIV=4, INIT=8'h01):
1. Reset, then en=1, mode=3 (ROL) → tick every 4th clk; data 01→02→04→…→80→01; wraps after 8 ticks.
2. mode=4 (ROR) from 01 → 80, 40, …; en=0 for 10 clks mid-run → data and tick frozen; resume continues from the held count.
3. mode=1 (SHL) with sin pattern 1,0,1,1 from 00 (loaded) → 01, 02, 05, 0B.
4. mode=5 (BOUNCE) from 01 → 02…80 (dir=0), next tick → 40 with dir=1, …, 01, next tick → 02 with dir=0; data=00 in bounce stays 00.
5. load=1, din=A5 on the same edge as tick in ROL → data=A5 (shift discarded); next tick → 4B; load with en=0 still yields data=din.
6. Assert rst for 1 clk mid-bounce (data=10, dir=1) → data=01, dir=0, tick low; next tick exactly 4 clks after rst release.
